// File: rtl/ps2_keymap.sv
// ps2_keymap: PS/2 frame receiver feeding a scancode-to-key level/pulse decoder.
// Build macro PS2_TYPEMATIC_FILTER_EN suppresses key_press on typematic repeats of a held key.
//   state  | meaning
//   IDLE   | waiting for a start bit (data=0 on a falling edge)
//   SHIFT  | collecting 8 data bits, LSB first
//   PARITY | capturing the odd-parity bit
//   STOP   | checking stop bit, then handing the byte to the decoder
module ps2_keymap #(
    parameter int                    NUM_KEYS       = 6,
    parameter logic [9*NUM_KEYS-1:0] KEY_CODES      = {9'h032, 9'h01C, 9'h174, 9'h16B, 9'h172, 9'h175},
    parameter int                    TIMEOUT_CYCLES = 50000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ps2_clk,
    input  logic                data,
    output logic [NUM_KEYS-1:0] key_state,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [7:0]          code,
    output logic                code_valid,
    output logic                frame_err
);

    localparam int              WD_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_RELOAD = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]      BRK_BYTE  = 8'hF0;
    localparam logic [7:0]      EXT_BYTE  = 8'hE0;

    typedef enum logic [1:0] {IDLE, SHIFT, PARITY, STOP} state_t;

    state_t              state, next_state;
    logic [1:0]          clk_sync, data_sync;
    logic                clk_prev;
    logic                fall, bit_in;
    logic [7:0]          shift_reg;
    logic [2:0]          bit_cnt;
    logic                par_bit;
    logic [WD_W-1:0]     wd;
    logic                brk, ext;
    logic                frame_good, frame_bad, timeout;
    logic [NUM_KEYS-1:0] match, press_mask;

    assign fall   = clk_prev & ~clk_sync[1];
    assign bit_in = data_sync[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], data};
            clk_prev  <= clk_sync[1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        frame_good = 1'b0;
        frame_bad  = 1'b0;
        timeout    = 1'b0;
        if (fall) begin
            case (state)
                IDLE:    if (!bit_in) next_state = SHIFT;
                SHIFT:   if (bit_cnt == 3'd7) next_state = PARITY;
                PARITY:  next_state = STOP;
                STOP: begin
                    next_state = IDLE;
                    if (bit_in && (^{shift_reg, par_bit})) frame_good = 1'b1;
                    else                                   frame_bad  = 1'b1;
                end
                default: next_state = IDLE;
            endcase
        end else if (state != IDLE && wd == '0) begin
            timeout    = 1'b1;
            next_state = IDLE;
        end
    end

    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_KEYS; i++)
            match[i] = (KEY_CODES[9*i +: 9] == {ext, shift_reg});
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    assign press_mask = match & ~key_state;
`else
    assign press_mask = match;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_reg  <= '0;
            bit_cnt    <= '0;
            par_bit    <= 1'b0;
            wd         <= '0;
            brk        <= 1'b0;
            ext        <= 1'b0;
            key_state  <= '0;
            key_press  <= '0;
            code       <= '0;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            key_press  <= '0;

            if (fall)                             wd <= WD_RELOAD;
            else if (state != IDLE && wd != '0)   wd <= wd - 1'b1;

            if (fall) begin
                case (state)
                    IDLE:    bit_cnt <= '0;
                    SHIFT: begin
                        shift_reg <= {bit_in, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 1'b1;
                    end
                    PARITY:  par_bit <= bit_in;
                    default: ;
                endcase
            end

            if (frame_bad || timeout) begin
                frame_err <= 1'b1;
                brk       <= 1'b0;
                ext       <= 1'b0;
            end

            if (frame_good) begin
                code       <= shift_reg;
                code_valid <= 1'b1;
                if (shift_reg == BRK_BYTE) begin
                    brk <= 1'b1;
                end else if (shift_reg == EXT_BYTE) begin
                    ext <= 1'b1;
                end else begin
                    brk <= 1'b0;
                    ext <= 1'b0;
                    if (brk) begin
                        key_state <= key_state & ~match;
                    end else begin
                        key_state <= key_state | match;
                        key_press <= press_mask;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_keymap.sv
// tb_ps2_keymap: table-driven, hand-written and randomized frames against a byte-level key model.
module tb_ps2_keymap;

    localparam int TMO = 400;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       data = 1'b1;
    logic [5:0] key_state, key_press;
    logic [7:0] code;
    logic       code_valid, frame_err;

    ps2_keymap #(.NUM_KEYS(6), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .data(data),
        .key_state(key_state), .key_press(key_press), .code(code),
        .code_valid(code_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cv_cnt = 0, err_cnt = 0, misalign = 0;
    int press_cnt[6];

    // key index -> {E0-extended, scancode}: up, down, left, right, a, b
    logic [8:0] key_tab[6] = '{9'h175, 9'h172, 9'h16B, 9'h174, 9'h01C, 9'h032};
    logic [5:0] m_ks = '0;
    logic       m_brk = 1'b0, m_ext = 1'b0;
    logic [7:0] m_code = '0;
    int         m_cv = 0, m_err = 0;
    int         m_press[6];

    typedef struct {
        logic [7:0] b;
        int         kind;   // 0 good, 1 bad parity, 2 bad stop
        logic [5:0] ks;
    } vec_t;
    vec_t tbl[23];

    always @(negedge clk) begin
        if (reset) begin
            if (code_valid) cv_cnt++;
            if (frame_err)  err_cnt++;
            if (key_press != '0 && !code_valid) misalign++;
            for (int k = 0; k < 6; k++) if (key_press[k]) press_cnt[k]++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        m_cv++;
        m_code = b;
        if (b == 8'hF0) m_brk = 1'b1;
        else if (b == 8'hE0) m_ext = 1'b1;
        else begin
            for (int i = 0; i < 6; i++) begin
                if (key_tab[i] == {m_ext, b}) begin
                    if (m_brk) m_ks[i] = 1'b0;
                    else begin
`ifdef PS2_TYPEMATIC_FILTER_EN
                        if (!m_ks[i]) m_press[i]++;
`else
                        m_press[i]++;
`endif
                        m_ks[i] = 1'b1;
                    end
                end
            end
            m_brk = 1'b0;
            m_ext = 1'b0;
        end
    endtask

    task automatic model_err();
        m_err++;
        m_brk = 1'b0;
        m_ext = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk) data = b;
        repeat (4) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (8) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input int kind);
        logic par;
        par = ~(^b);
        if (kind == 1) par = ~par;
        send_bit(1'b0);
        for (int k = 0; k < 8; k++) send_bit(b[k]);
        send_bit(par);
        send_bit(kind == 2 ? 1'b0 : 1'b1);
        data = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic check_all(input string tag);
        check({tag, "_ks"},   32'(key_state), 32'(m_ks));
        check({tag, "_code"}, 32'(code),      32'(m_code));
        check({tag, "_cv"},   cv_cnt,         m_cv);
        check({tag, "_err"},  err_cnt,        m_err);
        for (int k = 0; k < 6; k++)
            check($sformatf("%s_press%0d", tag, k), press_cnt[k], m_press[k]);
    endtask

    initial begin
        int p0, e0, waited, r;
        logic [7:0] rb;
        for (int k = 0; k < 6; k++) begin press_cnt[k] = 0; m_press[k] = 0; end

        tbl[0]  = '{8'h1C, 0, 6'b010000};
        tbl[1]  = '{8'hE0, 0, 6'b010000};
        tbl[2]  = '{8'h75, 0, 6'b010001};
        tbl[3]  = '{8'hE0, 0, 6'b010001};
        tbl[4]  = '{8'hF0, 0, 6'b010001};
        tbl[5]  = '{8'h75, 0, 6'b010000};
        tbl[6]  = '{8'hF0, 0, 6'b010000};
        tbl[7]  = '{8'h1C, 0, 6'b000000};
        tbl[8]  = '{8'hE0, 0, 6'b000000};
        tbl[9]  = '{8'h75, 1, 6'b000000};
        tbl[10] = '{8'h75, 0, 6'b000000};
        tbl[11] = '{8'hE0, 0, 6'b000000};
        tbl[12] = '{8'h75, 0, 6'b000001};
        tbl[13] = '{8'hFA, 0, 6'b000001};
        tbl[14] = '{8'hF0, 0, 6'b000001};
        tbl[15] = '{8'h32, 0, 6'b000001};
        tbl[16] = '{8'h32, 0, 6'b100001};
        tbl[17] = '{8'h1C, 0, 6'b110001};
        tbl[18] = '{8'hF0, 2, 6'b110001};
        tbl[19] = '{8'h1C, 0, 6'b110001};
        tbl[20] = '{8'h6B, 0, 6'b110001};
        tbl[21] = '{8'hE0, 0, 6'b110001};
        tbl[22] = '{8'h6B, 0, 6'b110101};

        repeat (5) @(negedge clk);
        check("rst_ks",    32'(key_state),  0);
        check("rst_press", 32'(key_press),  0);
        check("rst_code",  32'(code),       0);
        check("rst_cv",    32'(code_valid), 0);
        check("rst_err",   32'(frame_err),  0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 23; i++) begin
            send_frame(tbl[i].b, tbl[i].kind);
            if (tbl[i].kind == 0) model_byte(tbl[i].b);
            else                  model_err();
            check($sformatf("tbl%0d_ks", i), 32'(key_state), 32'(tbl[i].ks));
            check_all($sformatf("tbl%0d", i));
        end

        // Reset after the 6th data bit: frame abandoned silently.
        send_bit(1'b0);
        for (int k = 0; k < 6; k++) begin
            rb = 8'h1C;
            send_bit(rb[k]);
        end
        @(negedge clk) reset = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_ks",   32'(key_state),  0);
        check("midrst_code", 32'(code),       0);
        check("midrst_cv",   32'(code_valid), 0);
        check("midrst_err",  32'(frame_err),  0);
        reset = 1'b1;
        m_ks = '0; m_brk = 1'b0; m_ext = 1'b0; m_code = '0;
        repeat (20) @(negedge clk);
        check("midrst_noerr", err_cnt, m_err);

        // Typematic: three makes of key 4 from released state.
        p0 = press_cnt[4];
        for (int i = 0; i < 3; i++) begin
            send_frame(8'h1C, 0);
            model_byte(8'h1C);
            check_all($sformatf("typ%0d", i));
        end
`ifdef PS2_TYPEMATIC_FILTER_EN
        check("typ_pulses", press_cnt[4] - p0, 1);
`else
        check("typ_pulses", press_cnt[4] - p0, 3);
`endif
        check("typ_ks4", 32'(key_state[4]), 1);

        // Watchdog: start + 4 bits, then idle.
        send_bit(1'b0);
        for (int k = 0; k < 4; k++) send_bit(k[0]);
        e0 = err_cnt;
        waited = 0;
        while (err_cnt == e0 && waited < TMO + 100) begin
            @(negedge clk);
            waited++;
        end
        check("tmo_fired", err_cnt - e0, 1);
        check("tmo_window", 32'(waited >= TMO - 20 && waited <= TMO + 10), 1);
        model_err();
        repeat (10) @(negedge clk);
        check_all("tmo_after");
        send_frame(8'h32, 0);
        model_byte(8'h32);
        check("tmo_key5", 32'(key_state[5]), 1);
        check_all("tmo_32");

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            if (r < 2)      rb = 8'hE0;
            else if (r < 4) rb = 8'hF0;
            else if (r < 8) rb = key_tab[$urandom_range(0, 5)][7:0];
            else            rb = 8'($urandom);
            r = ($urandom_range(0, 9) == 0) ? 1 : 0;
            send_frame(rb, r);
            if (r == 0) model_byte(rb);
            else        model_err();
            check_all($sformatf("rnd%0d", i));
        end

        check("press_with_cv", misalign, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
